// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multi-cycle sequencer owning the CPU's shared memory port
module mem_access_seq #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] store_data,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_halt,
    input  logic [WORD_SIZE-1:0] mem_data_in,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_oe,
    output logic [WORD_SIZE-1:0] ir,
    output logic [WORD_SIZE-1:0] mdr,
    output logic                 commit,
    output logic                 halted,
    output logic                 timeout_err,
    output logic [WORD_SIZE-1:0] num_inst
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_COMMIT, S_HALT, S_ERROR
    } state_t;

    localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d, mdr_q, mdr_d, num_q, num_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 readm_q, writem_q, commit_q, halted_q, timeout_q;
    logic                 waiting, hs;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        waiting = 1'b0;
        hs      = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                waiting = 1'b1;
                hs      = inputReady;
                if (inputReady) begin
                    ir_d    = mem_data_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt)       state_d = S_HALT;
                else if (is_load)  state_d = S_MEM_RD;
                else if (is_store) state_d = S_MEM_WR;
                else               state_d = S_COMMIT;
            end
            S_MEM_RD: begin
                waiting = 1'b1;
                hs      = inputReady;
                if (inputReady) begin
                    mdr_d   = mem_data_in;
                    state_d = S_COMMIT;
                end
            end
            S_MEM_WR: begin
                waiting = 1'b1;
                hs      = ackOutput;
                if (ackOutput) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                num_d   = num_q + 1'b1;
                state_d = S_FETCH;
            end
            default: ;
        endcase
        // A handshake in the limit cycle takes priority over the timeout.
        if (waiting && !hs) begin
            cnt_d = cnt_q + 1'b1;
            if (TIMEOUT_EN && cnt_q == LAST_WAIT) state_d = S_ERROR;
        end
        if (state_d != state_q) cnt_d = '0;
    end

    // Strobes are registered from the next state so they are glitch-free and
    // depend only on the sequencer state, never directly on an input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            mdr_q     <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            readm_q   <= 1'b0;
            writem_q  <= 1'b0;
            commit_q  <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            readm_q   <= (state_d == S_FETCH) || (state_d == S_MEM_RD);
            writem_q  <= (state_d == S_MEM_WR);
            commit_q  <= (state_d == S_COMMIT);
            halted_q  <= (state_d == S_HALT);
            timeout_q <= (state_d == S_ERROR);
        end
    end

    always_comb begin
        address  = '0;
        data_out = '0;
        case (state_q)
            S_FETCH:  address = pc;
            S_MEM_RD: address = mem_addr;
            S_MEM_WR: begin
                address  = mem_addr;
                data_out = store_data;
            end
            default: ;
        endcase
    end

    assign readM       = readm_q;
    assign writeM      = writem_q;
    assign data_oe     = writem_q;
    assign commit      = commit_q;
    assign halted      = halted_q;
    assign timeout_err = timeout_q;
    assign ir          = ir_q;
    assign mdr         = mdr_q;
    assign num_inst    = num_q;
endmodule
